// File: rtl/bitbakery_serial_pkg.sv
// Shared definitions for the serial packet transmitter: FSM state codes,
// parity modes and default framing bytes.
package bitbakery_serial_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START_BIT  = 3'd1,
      DATA_BITS  = 3'd2,
      PARITY_BIT = 3'd3,
      STOP_BIT   = 3'd4
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam logic [7:0] DEF_START_BYTE = 8'hFF;
   localparam logic [7:0] DEF_END_BYTE   = 8'hFE;

endpackage

// File: rtl/bitbakery_uart_framer.sv
// Single-byte UART framer: start, 8 data bits LSB first, optional parity, stop.
// Chains straight into the next frame when i_next is high at the end of stop.
module bitbakery_uart_framer
   import bitbakery_serial_pkg::*;
#(
   parameter int CLK_PER_BIT = 434,
   parameter int PARITY      = PAR_EVEN
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_go,
   input  logic       i_next,
   input  logic [7:0] i_byte,
   output logic       o_serial,
   output logic       o_busy,
   output logic       o_frame_end,
   output state_t     o_state
);

   localparam int             TW        = $clog2(CLK_PER_BIT);
   localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_PER_BIT - 1);
   localparam logic           PAR_INV   = (PARITY == PAR_ODD);

   state_t          r_state;
   logic [TW-1:0]   r_tick;
   logic [2:0]      r_bitn;
   logic [7:0]      r_shift;
   logic            r_par;
   logic            r_serial;
   logic            r_busy;
   logic            w_bit_end;

   assign w_bit_end   = (r_tick == TICK_LAST);
   assign o_frame_end = (r_state == STOP_BIT) && w_bit_end;
   assign o_state     = r_state;
   assign o_serial    = r_serial;
   assign o_busy      = r_busy;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_tick   <= '0;
         r_bitn   <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_serial <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         if (r_state != IDLE)
            r_tick <= w_bit_end ? '0 : r_tick + 1'b1;
         case (r_state)
            IDLE: begin
               if (i_go) begin
                  r_state  <= START_BIT;
                  r_serial <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            // byte is sampled at the end of the start bit, once the buffer is stable
            START_BIT: begin
               if (w_bit_end) begin
                  r_state  <= DATA_BITS;
                  r_shift  <= i_byte;
                  r_serial <= i_byte[0];
                  r_bitn   <= '0;
                  r_par    <= (^i_byte) ^ PAR_INV;
               end
            end
            DATA_BITS: begin
               if (w_bit_end) begin
                  if (r_bitn == 3'd7) begin
                     if (PARITY == PAR_NONE) begin
                        r_state  <= STOP_BIT;
                        r_serial <= 1'b1;
                     end else begin
                        r_state  <= PARITY_BIT;
                        r_serial <= r_par;
                     end
                  end else begin
                     r_bitn   <= r_bitn + 1'b1;
                     r_shift  <= r_shift >> 1;
                     r_serial <= r_shift[1];
                  end
               end
            end
            PARITY_BIT: begin
               if (w_bit_end) begin
                  r_state  <= STOP_BIT;
                  r_serial <= 1'b1;
               end
            end
            STOP_BIT: begin
               if (w_bit_end) begin
                  if (i_next) begin
                     r_state  <= START_BIT;
                     r_serial <= 1'b0;
                  end else begin
                     r_state  <= IDLE;
                     r_busy   <= 1'b0;
                  end
               end
            end
            default: begin
               r_state  <= IDLE;
               r_serial <= 1'b1;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bitbakery_serial_packet_tx.sv
// Packet transmitter: snapshots framing + status + map bytes on iniciar and
// streams them back to back through the byte framer.
module bitbakery_serial_packet_tx
   import bitbakery_serial_pkg::*;
#(
   parameter int         N_DATA      = 3,
   parameter int         MAP_BYTES   = 64,
   parameter int         CLK_PER_BIT = 434,
   parameter int         PARITY      = PAR_EVEN,
   parameter logic [7:0] START_BYTE  = DEF_START_BYTE,
   parameter logic [7:0] END_BYTE    = DEF_END_BYTE
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic                                          iniciar,
   input  logic [8*N_DATA-1:0]                           dados,
   input  logic [(MAP_BYTES > 0 ? 8*MAP_BYTES : 8)-1:0]  map_data,
   output logic                                          saida_serial,
   output logic                                          ocupado,
   output logic                                          pronto,
   output logic [2:0]                                    db_estado
);

   localparam int L     = N_DATA + MAP_BYTES + 2;
   localparam int IDX_W = $clog2(L);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(L - 1);

   logic [8*L-1:0]   r_buf;
   logic [IDX_W-1:0] r_idx;
   logic             r_pronto;
   logic [8*L-1:0]   w_pkt;
   logic [7:0]       w_byte;
   logic             w_accept;
   logic             w_next;
   logic             w_frame_end;
   state_t           w_state;

   // framing bytes live in the buffer too, so byte selection is one flat index
   generate
      if (MAP_BYTES > 0) begin : g_map
         assign w_pkt = {END_BYTE, map_data, dados, START_BYTE};
      end else begin : g_nomap
         assign w_pkt = {END_BYTE, dados, START_BYTE};
      end
   endgenerate

   assign w_accept = iniciar && (w_state == IDLE);
   assign w_next   = (r_idx != IDX_LAST);
   assign w_byte   = r_buf[{r_idx, 3'b000} +: 8];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_buf    <= '0;
         r_idx    <= '0;
         r_pronto <= 1'b0;
      end else begin
         r_pronto <= w_frame_end && !w_next;
         if (w_accept) begin
            r_buf <= w_pkt;
            r_idx <= '0;
         end else if (w_frame_end) begin
            r_idx <= w_next ? r_idx + 1'b1 : '0;
         end
      end
   end

   bitbakery_uart_framer #(
      .CLK_PER_BIT (CLK_PER_BIT),
      .PARITY      (PARITY)
   ) u_framer (
      .i_clk       (clock),
      .i_rst       (reset),
      .i_go        (w_accept),
      .i_next      (w_next),
      .i_byte      (w_byte),
      .o_serial    (saida_serial),
      .o_busy      (ocupado),
      .o_frame_end (w_frame_end),
      .o_state     (w_state)
   );

   assign pronto    = r_pronto;
   assign db_estado = w_state;

endmodule

// File: tb/tb_bitbakery_serial_packet_tx.sv
// Bench for bitbakery_serial_packet_tx: four configurations checked every cycle
// against a frame-level waveform model, plus hand-computed literal expectations.
module tb_bitbakery_serial_packet_tx;

   typedef struct packed {
      logic       ser;
      logic       busy;
      logic       pr;
      logic [2:0] st;
   } exp_t;

   localparam exp_t IDLE_E = '{ser: 1'b1, busy: 1'b0, pr: 1'b0, st: 3'd0};

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   ini = '0;
   logic [23:0]  dados0 = 24'h010203;
   logic [23:0]  dados_s = 24'h3C8117;
   logic [7:0]   dados3 = 8'h5A;
   logic [511:0] map0;
   logic [7:0]   map3 = 8'h00;
   logic [3:0]   ser, busy, pr;
   logic [2:0]   st [4];

   int errors = 0;
   int checks = 0;

   exp_t       mem [4][4096];
   int         head [4] = '{0, 0, 0, 0};
   int         tail [4] = '{0, 0, 0, 0};
   logic [7:0] pk [70];
   logic       rec [0:4100];

   always #5 clk = ~clk;

   bitbakery_serial_packet_tx #(.CLK_PER_BIT(4)) u0 (
      .clock(clk), .reset(rst), .iniciar(ini[0]), .dados(dados0), .map_data(map0),
      .saida_serial(ser[0]), .ocupado(busy[0]), .pronto(pr[0]), .db_estado(st[0]));

   bitbakery_serial_packet_tx #(.CLK_PER_BIT(4), .PARITY(2)) u1 (
      .clock(clk), .reset(rst), .iniciar(ini[1]), .dados(dados_s), .map_data(map0),
      .saida_serial(ser[1]), .ocupado(busy[1]), .pronto(pr[1]), .db_estado(st[1]));

   bitbakery_serial_packet_tx #(.CLK_PER_BIT(4), .PARITY(0)) u2 (
      .clock(clk), .reset(rst), .iniciar(ini[2]), .dados(dados_s), .map_data(map0),
      .saida_serial(ser[2]), .ocupado(busy[2]), .pronto(pr[2]), .db_estado(st[2]));

   bitbakery_serial_packet_tx #(.N_DATA(1), .MAP_BYTES(0), .CLK_PER_BIT(4)) u3 (
      .clock(clk), .reset(rst), .iniciar(ini[3]), .dados(dados3), .map_data(map3),
      .saida_serial(ser[3]), .ocupado(busy[3]), .pronto(pr[3]), .db_estado(st[3]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   task automatic emit(input int id, input logic s, input logic b, input logic p,
                       input logic [2:0] stt, input int reps);
      for (int r = 0; r < reps; r++) begin
         mem[id][tail[id] % 4096] = '{ser: s, busy: b, pr: p, st: stt};
         tail[id]++;
      end
   endtask

   // expected waveform: every bit of every frame held 4 cycles, then one pronto cycle
   task automatic build(input int id);
      int nb, par;
      logic [7:0] by;
      logic pbit;
      logic [23:0] dd;
      pk[0] = 8'hFF;
      if (id == 3) begin
         pk[1] = dados3; pk[2] = 8'hFE; nb = 3; par = 1;
      end else begin
         dd = (id == 0) ? dados0 : dados_s;
         for (int i = 0; i < 3; i++)  pk[1 + i] = dd[8*i +: 8];
         for (int i = 0; i < 64; i++) pk[4 + i] = map0[8*i +: 8];
         pk[68] = 8'hFE; nb = 69;
         par = (id == 0) ? 1 : (id == 1) ? 2 : 0;
      end
      for (int b = 0; b < nb; b++) begin
         by = pk[b];
         emit(id, 1'b0, 1'b1, 1'b0, 3'd1, 4);
         for (int k = 0; k < 8; k++) emit(id, by[k], 1'b1, 1'b0, 3'd2, 4);
         if (par != 0) begin
            pbit = ($countones(by) % 2) == 1;
            if (par == 2) pbit = !pbit;
            emit(id, pbit, 1'b1, 1'b0, 3'd3, 4);
         end
         emit(id, 1'b1, 1'b1, 1'b0, 3'd4, 4);
      end
      emit(id, 1'b1, 1'b0, 1'b1, 3'd0, 1);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) head[i] = tail[i];
      end else begin
         for (int i = 0; i < 4; i++)
            if (head[i] == tail[i] && ini[i]) build(i);
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         exp_t e, g;
         if (head[i] != tail[i]) begin
            e = mem[i][head[i] % 4096];
            head[i]++;
         end else begin
            e = IDLE_E;
         end
         g = {ser[i], busy[i], pr[i], st[i]};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL model dut%0d t=%0t: got ser/busy/pr/st=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     i, $time, g.ser, g.busy, g.pr, g.st, e.ser, e.busy, e.pr, e.st);
         end
      end
   end

   function automatic logic [10:0] frame(input int s);
      logic [10:0] f;
      for (int k = 0; k < 11; k++) f[k] = rec[s + 4*k + 1];
      return f;
   endfunction

   task automatic start_capture(input int id, input bit chg, input bit midini,
                                output int np, output int nbusy);
      int n;
      @(negedge clk); ini[id] = 1'b1;
      @(posedge clk); #1; ini[id] = 1'b0;
      if (chg) dados0 = 24'hAABBCC;
      n = 0; nbusy = 0;
      rec[0] = ser[id];
      if (busy[id]) nbusy++;
      while (!pr[id] && n < 4000) begin
         @(posedge clk); #1; n++;
         if (midini && n == 1000) ini[id] = 1'b1;
         if (midini && n == 1001) ini[id] = 1'b0;
         rec[n] = ser[id];
         if (busy[id]) nbusy++;
      end
      np = n;
   endtask

   initial begin
      int np, nb, n, cnt;
      for (int i = 0; i < 64; i++) map0[8*i +: 8] = 8'((i * 3 + 7) % 256);
      #1 rst = 1'b1;
      #1;
      check("reset ser", {28'd0, ser}, 32'hF);
      check("reset busy", {28'd0, busy}, 32'h0);
      check("reset pronto", {28'd0, pr}, 32'h0);
      check("reset state", {29'd0, st[0]}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // defaults, dados changed after iniciar, stray iniciar mid-packet
      start_capture(0, 1'b1, 1'b1, np, nb);
      check("d0 pronto latency", np, 3036);
      check("d0 busy cycles", nb, 3036);
      check("d0 first frame", {21'd0, frame(0)}, 32'b10111111110);
      check("d0 last frame", {21'd0, frame(2992)}, 32'b11111111100);
      check("d0 byte1", {24'd0, frame(44)[8:1]}, 32'h03);
      check("d0 byte2", {24'd0, frame(88)[8:1]}, 32'h02);
      check("d0 byte3", {24'd0, frame(132)[8:1]}, 32'h01);

      // iniciar during the pronto cycle
      ini[0] = 1'b1;
      @(posedge clk); #1; ini[0] = 1'b0;
      check("restart ser low", {31'd0, ser[0]}, 32'd0);
      check("restart busy", {31'd0, busy[0]}, 32'd1);
      n = 0;
      while (!pr[0] && n < 4000) begin @(posedge clk); #1; n++; end
      check("restart pronto latency", n, 3036);

      start_capture(1, 1'b0, 1'b0, np, nb);
      check("odd pronto latency", np, 3036);
      check("odd end parity", {31'd0, frame(2992)[9]}, 32'd0);
      check("odd end stop", {31'd0, frame(2992)[10]}, 32'd1);

      start_capture(2, 1'b0, 1'b0, np, nb);
      check("nopar pronto latency", np, 2760);
      check("nopar first frame", {22'd0, frame(0)[9:0]}, 32'b1111111110);
      check("nopar last frame", {22'd0, frame(2720)[9:0]}, 32'b1111111100);

      start_capture(3, 1'b0, 1'b0, np, nb);
      check("small pronto latency", np, 132);
      check("small busy cycles", nb, 132);
      check("small frame0", {21'd0, frame(0)}, 32'b10111111110);
      check("small data", {24'd0, frame(44)[8:1]}, 32'h5A);
      check("small end frame", {21'd0, frame(88)}, 32'b11111111100);

      // reset during frame 10 (cycles 440..483 of the packet)
      @(negedge clk); ini[0] = 1'b1;
      @(posedge clk); #1; ini[0] = 1'b0;
      repeat (450) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midreset ser", {31'd0, ser[0]}, 32'd1);
      check("midreset busy", {31'd0, busy[0]}, 32'd0);
      check("midreset state", {29'd0, st[0]}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (100) begin @(posedge clk); #1; if (pr[0]) cnt++; end
      check("midreset no pronto", cnt, 0);
      start_capture(0, 1'b0, 1'b0, np, nb);
      check("after reset first frame", {21'd0, frame(0)}, 32'b10111111110);
      check("after reset pronto latency", np, 3036);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
